// File: rtl/frontier_mem_tester_pkg.sv
// Shared types, default geometry and the address-derived test pattern for the memory tester.
package frontier_mem_tester_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 1024;
  localparam int unsigned SEED_W     = 32;
  localparam int unsigned PAT_A_W    = 10;
  localparam int unsigned ERR_W      = 11;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Address replicated into both half-words so upper and lower data bits both see it.
  function automatic logic [SEED_W-1:0] pattern(input logic [SEED_W-1:0]  seed,
                                                input logic [PAT_A_W-1:0] a);
    return seed ^ {6'b0, a, 6'b0, a};
  endfunction

endpackage

// File: rtl/frontier_mem_tester_cmp.sv
// Read-scoring pipeline: registers each issued read address and checks the returned word next cycle.
module frontier_mem_tester_cmp
  import frontier_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              rd_issue,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] readdata,
  input  logic [SEED_W-1:0] seed_q,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              miss_c
);

  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(DEPTH);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] expected;

  always_comb begin
    expected = DATA_W'(pattern(seed_q, PAT_A_W'(addr_q)));
    miss_c   = valid_q && (readdata != expected);
  end

  // Count saturates at DEPTH; the first failing address is latched only while the count is zero.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      valid_q        <= 1'b0;
      addr_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      valid_q <= rd_issue;
      addr_q  <= rd_addr;
      if (miss_c) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + ERR_W'(1);
        end
        if (err_count == '0) begin
          first_err_addr <= addr_q;
        end
      end
    end
  end

endmodule

// File: rtl/frontier_mem_tester.sv
// Memory tester: writes a seeded pattern to every word, reads it all back and reports mismatches.
module frontier_mem_tester
  import frontier_mem_tester_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEED_W-1:0] seed,
  output logic [ADDR_W-1:0] address,
  output logic [BE_W-1:0]   byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic              clken,
  input  logic [DATA_W-1:0] readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [ADDR_W-1:0] address_d;
  logic              accept;
  logic              miss_c;
  logic              cs_d, wr_d, busy_d, done_d, pass_d;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] wd_d;

  assign clken = 1'b1;

  // State and seed registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
    end
  end

  // Next-state and address sequencing.
  always_comb begin
    state_d   = state_q;
    address_d = address;
    seed_d    = seed_q;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          seed_d    = seed;
          address_d = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (address == LAST_ADDR) begin
          address_d = '0;
          state_d   = ST_READ;
        end else begin
          address_d = address + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (address == LAST_ADDR) begin
          address_d = '0;
          state_d   = ST_DRAIN;
        end else begin
          address_d = address + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    cs_d   = (state_d == ST_WRITE) || (state_d == ST_READ);
    wr_d   = (state_d == ST_WRITE);
    be_d   = cs_d ? {BE_W{1'b1}} : '0;
    wd_d   = wr_d ? DATA_W'(pattern(seed_d, PAT_A_W'(address_d))) : '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    pass_d = pass;
    if (accept) begin
      pass_d = 1'b0;
    end else if (state_q == ST_DRAIN) begin
      // The last compare lands in DRAIN, so fold it in alongside the running count.
      pass_d = (err_count == '0) && !miss_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address    <= '0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      byteenable <= '0;
      writedata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      address    <= address_d;
      chipselect <= cs_d;
      write      <= wr_d;
      byteenable <= be_d;
      writedata  <= wd_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

  frontier_mem_tester_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clr            (accept),
    .rd_issue       (state_q == ST_READ),
    .rd_addr        (address),
    .readdata       (readdata),
    .seed_q         (seed_q),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .miss_c         (miss_c)
  );

endmodule

// File: tb/tb_frontier_mem_tester.sv
// Directed bench for frontier_mem_tester with a 1024x32 one-cycle-latency slave model.
module tb_frontier_mem_tester;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] seed;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] err_count;
  logic [9:0]  first_err_addr;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  logic [31:0] wd0, wd3ff;

  logic [31:0] mem [0:1023];
  logic [9:0]  raddr_q = '0;

  always #5 clk = ~clk;

  frontier_mem_tester dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .seed           (seed),
    .address        (address),
    .byteenable     (byteenable),
    .chipselect     (chipselect),
    .write          (write),
    .writedata      (writedata),
    .clken          (clken),
    .readdata       (readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  // Slave: byte-enabled writes, registered read address, data driven combinationally from it.
  always @(posedge clk) begin
    if (chipselect && write) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[address][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
    if (chipselect && !write) raddr_q <= address;
  end

  function automatic logic [31:0] fmask(input int m, input logic [9:0] a);
    if (m == 1 && (a == 10'd5 || a == 10'd700)) return 32'h0000_0001;
    if (m == 2) return 32'hFFFF_FFFF;
    return 32'h0;
  endfunction

  assign readdata = mem[raddr_q] ^ fmask(fault_mode, raddr_q);

  // Pulse start, then follow the run until done or the cycle budget runs out.
  task automatic run_test(input logic [31:0] s, input bit spam, output int cyc, output logic busy1);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    wd0   = 32'h0;
    wd3ff = 32'h0;
    forever begin
      if (write && address == 10'h000) wd0 = writedata;
      if (write && address == 10'h3FF) wd3ff = writedata;
      if (done || cyc >= 3000) break;
      @(negedge clk);
      cyc++;
      start = spam && (cyc < 2040) && (cyc % 3 == 0);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    seed  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (address !== 10'h0)    begin errors++; $display("FAIL reset_address got %h want 0", address); end
    checks++; if (chipselect !== 1'b0)  begin errors++; $display("FAIL reset_chipselect got %b want 0", chipselect); end
    checks++; if (write !== 1'b0)       begin errors++; $display("FAIL reset_write got %b want 0", write); end
    checks++; if (byteenable !== 4'h0)  begin errors++; $display("FAIL reset_byteenable got %h want 0", byteenable); end
    checks++; if (writedata !== 32'h0)  begin errors++; $display("FAIL reset_writedata got %h want 0", writedata); end
    checks++; if (clken !== 1'b1)       begin errors++; $display("FAIL reset_clken got %b want 1", clken); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0)
      begin errors++; $display("FAIL reset_flags got busy=%b done=%b pass=%b want 0/0/0", busy, done, pass); end
    checks++; if (err_count !== 11'd0 || first_err_addr !== 10'd0)
      begin errors++; $display("FAIL reset_score got err=%0d first=%0d want 0/0", err_count, first_err_addr); end
    reset = 1'b0;
  endtask

  task automatic test_clean();
    int cyc; logic b1;
    fault_mode = 0;
    run_test(32'h0, 1'b0, cyc, b1);
    checks++; if (cyc !== 2050) begin errors++; $display("FAIL clean_latency got %0d want 2050", cyc); end
    checks++; if (b1 !== 1'b1)  begin errors++; $display("FAIL clean_busy_c1 got %b want 1", b1); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass got %b want 1", pass); end
    checks++; if (err_count !== 11'd0) begin errors++; $display("FAIL clean_err got %0d want 0", err_count); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL clean_after_done got done=%b busy=%b want 0/0", done, busy); end
    repeat (5) @(negedge clk);
    checks++; if (pass !== 1'b1 || err_count !== 11'd0)
      begin errors++; $display("FAIL clean_hold got pass=%b err=%0d want 1/0", pass, err_count); end
  endtask

  task automatic test_pattern();
    int cyc; logic b1;
    fault_mode = 0;
    run_test(32'hFFFF_FFFF, 1'b0, cyc, b1);
    checks++; if (wd0 !== 32'hFFFF_FFFF)   begin errors++; $display("FAIL pattern_a000 got %h want FFFFFFFF", wd0); end
    checks++; if (wd3ff !== 32'hFC00_FC00) begin errors++; $display("FAIL pattern_a3ff got %h want FC00FC00", wd3ff); end
    checks++; if (pass !== 1'b1 || cyc !== 2050)
      begin errors++; $display("FAIL pattern_run got pass=%b cyc=%0d want 1/2050", pass, cyc); end
  endtask

  task automatic test_fault();
    int cyc; logic b1;
    fault_mode = 1;
    run_test(32'hA5A5_0F0F, 1'b0, cyc, b1);
    checks++; if (cyc !== 2050) begin errors++; $display("FAIL fault_latency got %0d want 2050", cyc); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fault_pass got %b want 0", pass); end
    checks++; if (err_count !== 11'd2) begin errors++; $display("FAIL fault_err got %0d want 2", err_count); end
    checks++; if (first_err_addr !== 10'd5) begin errors++; $display("FAIL fault_first got %0d want 5", first_err_addr); end
  endtask

  task automatic test_start_spam();
    int cyc; logic b1; int extra_done;
    fault_mode = 1;
    run_test(32'h1357_9BDF, 1'b1, cyc, b1);
    checks++; if (cyc !== 2050) begin errors++; $display("FAIL spam_latency got %0d want 2050", cyc); end
    checks++; if (err_count !== 11'd2 || first_err_addr !== 10'd5 || pass !== 1'b0)
      begin errors++; $display("FAIL spam_result got err=%0d first=%0d pass=%b want 2/5/0", err_count, first_err_addr, pass); end
    extra_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    checks++; if (extra_done !== 0) begin errors++; $display("FAIL spam_single_done got %0d busy/done cycles want 0", extra_done); end
  endtask

  task automatic test_reset_mid();
    int n; int seen_done; int cyc; logic b1;
    fault_mode = 2;
    @(negedge clk);
    seed  = 32'h0F0F_1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(chipselect && !write && address == 10'd300) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 3000) begin errors++; $display("FAIL midrst_reach got timeout want read of 300"); end
    checks++; if (err_count !== 11'd299) begin errors++; $display("FAIL midrst_err_before got %0d want 299", err_count); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (chipselect !== 1'b0 || busy !== 1'b0 || err_count !== 11'd0 || done !== 1'b0)
      begin errors++; $display("FAIL midrst_after got cs=%b busy=%b err=%0d done=%b want 0/0/0/0", chipselect, busy, err_count, done); end
    reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", seen_done); end
    fault_mode = 0;
    run_test(32'h0F0F_1234, 1'b0, cyc, b1);
    checks++; if (cyc !== 2050 || pass !== 1'b1 || err_count !== 11'd0)
      begin errors++; $display("FAIL midrst_rerun got cyc=%0d pass=%b err=%0d want 2050/1/0", cyc, pass, err_count); end
  endtask

  task automatic test_saturate();
    int cyc; logic b1;
    fault_mode = 2;
    run_test(32'h0BAD_F00D, 1'b0, cyc, b1);
    checks++; if (err_count !== 11'd1024) begin errors++; $display("FAIL sat_err got %0d want 1024", err_count); end
    checks++; if (first_err_addr !== 10'd0) begin errors++; $display("FAIL sat_first got %0d want 0", first_err_addr); end
    checks++; if (pass !== 1'b0 || cyc !== 2050)
      begin errors++; $display("FAIL sat_run got pass=%b cyc=%0d want 0/2050", pass, cyc); end
    fault_mode = 0;
    repeat (4) @(negedge clk);
    checks++; if (err_count !== 11'd1024 || pass !== 1'b0)
      begin errors++; $display("FAIL sat_hold got err=%0d pass=%b want 1024/0", err_count, pass); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_pattern();
    test_fault();
    test_start_spam();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
